// File: rtl/unified_mem_ctrl_pkg.sv
// Shared encodings for the unified instruction/data memory controller.
// The FSM state type, beat count and request-field encodings live here.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
      ST_FETCH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int   WORD_BEATS = 4;
   localparam logic SIZE_BYTE  = 1'b0;
   localparam logic SIZE_WORD  = 1'b1;
   localparam logic RW_READ    = 1'b0;
   localparam logic RW_WRITE   = 1'b1;

   // A byte transfer is a single beat; a word transfer ends on beat WORD_BEATS-1.
   function automatic logic is_last_beat(input logic size, input logic [1:0] beat);
      return (size == SIZE_BYTE) || (beat == 2'(WORD_BEATS - 1));
   endfunction

endpackage

// File: rtl/unified_mem_ctrl_if.sv
// Bus bundle between the CPU-side ports, the controller and the byte-wide memory.
// master = CPU/memory side, slave = the controller.
interface unified_mem_ctrl_if;
   logic        if_req;
   logic [7:0]  if_addr;
   logic [31:0] if_data;
   logic        if_ready;
   logic        d_req;
   logic        d_rw;
   logic        d_size;
   logic [7:0]  d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   logic        stall;
   logic [7:0]  mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   modport master (
      output if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_rdata,
      input  if_data, if_ready, d_rdata, d_ready, stall, mem_addr, mem_wdata, mem_we
   );

   modport slave (
      input  if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_rdata,
      output if_data, if_ready, d_rdata, d_ready, stall, mem_addr, mem_wdata, mem_we
   );
endinterface

// File: rtl/unified_mem_ctrl_word_assembler.sv
// Big-endian byte<->word lane steering: beat k owns word bits [31-8k:24-8k].
// Byte transfers always use bits [7:0]; byte reads are zero-extended.
module word_assembler
   import mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        capture,
   input  logic        size,
   input  logic [1:0]  beat,
   input  logic [31:0] wdata,
   input  logic [7:0]  rdata_byte,
   output logic [7:0]  lane_byte,
   output logic [31:0] word_next
);

   logic [1:0] lane_idx;

   assign lane_idx  = 2'(WORD_BEATS - 1) - beat;
   assign lane_byte = (size == SIZE_BYTE) ? wdata[7:0] : wdata[{lane_idx, 3'b000} +: 8];

   // word_next includes the byte arriving this cycle so the final beat can be
   // registered straight into the port's result register.
   generate
      for (genvar gi = 0; gi < WORD_BEATS; gi++) begin : g_lane
         logic       hit;
         logic [7:0] lane_reg;

         assign hit = (size == SIZE_WORD) && (lane_idx == 2'(gi));

         always_ff @(posedge clk) begin
            if (reset) begin
               lane_reg <= 8'h00;
            end else if (capture && hit) begin
               lane_reg <= rdata_byte;
            end
         end

         if (gi == 0) begin : g_low
            assign word_next[7:0] = ((size == SIZE_BYTE) || hit) ? rdata_byte : lane_reg;
         end else begin : g_high
            assign word_next[8*gi +: 8] = (size == SIZE_BYTE) ? 8'h00 :
                                          (hit ? rdata_byte : lane_reg);
         end
      end
   endgenerate

endmodule

// File: rtl/unified_mem_ctrl.sv
// Arbitrates instruction fetch and data load/store onto one byte-wide memory,
// sequencing big-endian word transfers as four beats. Data has priority.
module unified_mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic            Clk,
   input  logic            Reset,
   unified_mem_ctrl_if.slave bus
);

   state_t      state_reg;
   logic [7:0]  base_reg;
   logic        rw_reg;
   logic        size_reg;
   logic [1:0]  beat_reg;
   logic [31:0] wdata_reg;
   logic        if_ready_reg;
   logic        d_ready_reg;
   logic [31:0] if_data_reg;
   logic [31:0] d_rdata_reg;

   logic        busy;
   logic        write_beat;
   logic        read_beat;
   logic [7:0]  lane_byte;
   logic [31:0] word_next;

   assign busy       = (state_reg == ST_DATA) || (state_reg == ST_FETCH);
   assign write_beat = busy && (rw_reg == RW_WRITE);
   assign read_beat  = busy && (rw_reg == RW_READ);

   // Reset gates the strobe so a reset landing mid-write stops the very next store.
   assign bus.mem_we    = write_beat && !Reset;
   assign bus.mem_addr  = busy ? (base_reg + {6'b000000, beat_reg}) : 8'h00;
   assign bus.mem_wdata = write_beat ? lane_byte : 8'h00;

   assign bus.if_ready = if_ready_reg;
   assign bus.d_ready  = d_ready_reg;
   assign bus.if_data  = if_data_reg;
   assign bus.d_rdata  = d_rdata_reg;
   assign bus.stall    = (bus.if_req && !if_ready_reg) || (bus.d_req && !d_ready_reg);

   word_assembler u_word_assembler (
      .clk        (Clk),
      .reset      (Reset),
      .capture    (read_beat),
      .size       (size_reg),
      .beat       (beat_reg),
      .wdata      (wdata_reg),
      .rdata_byte (bus.mem_rdata),
      .lane_byte  (lane_byte),
      .word_next  (word_next)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg    <= ST_IDLE;
         base_reg     <= 8'h00;
         rw_reg       <= RW_READ;
         size_reg     <= SIZE_BYTE;
         beat_reg     <= 2'd0;
         wdata_reg    <= 32'h0;
         if_ready_reg <= 1'b0;
         d_ready_reg  <= 1'b0;
         if_data_reg  <= 32'h0;
         d_rdata_reg  <= 32'h0;
      end else begin
         if_ready_reg <= 1'b0;
         d_ready_reg  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               beat_reg <= 2'd0;
               if (bus.d_req) begin
                  base_reg  <= bus.d_addr;
                  rw_reg    <= bus.d_rw;
                  size_reg  <= bus.d_size;
                  wdata_reg <= bus.d_wdata;
                  state_reg <= ST_DATA;
               end else if (bus.if_req) begin
                  base_reg  <= bus.if_addr;
                  rw_reg    <= RW_READ;
                  size_reg  <= SIZE_WORD;
                  state_reg <= ST_FETCH;
               end
            end
            ST_DATA, ST_FETCH: begin
               if (is_last_beat(size_reg, beat_reg)) begin
                  state_reg <= ST_DONE;
                  if (state_reg == ST_DATA) begin
                     d_ready_reg <= 1'b1;
                     if (rw_reg == RW_READ) begin
                        d_rdata_reg <= word_next;
                     end
                  end else begin
                     if_ready_reg <= 1'b1;
                     if_data_reg  <= word_next;
                  end
               end else begin
                  beat_reg <= beat_reg + 2'd1;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a transaction-level timeline model.
module tb_unified_mem_ctrl;

   logic Clk = 1'b0;
   logic Reset = 1'b1;

   unified_mem_ctrl_if bus();

   unified_mem_ctrl dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   // Byte memory seen by the DUT, plus a backdoor preload port.
   bit [7:0]   mem [256];
   logic       pl_we = 1'b0;
   logic [7:0] pl_addr = 8'h00;
   logic [7:0] pl_data = 8'h00;

   assign bus.mem_rdata = mem[bus.mem_addr];

   always @(posedge Clk) begin
      if (pl_we) mem[pl_addr] <= pl_data;
      else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a transaction accepted in cycle s with n beats puts beat k
   // on the memory in cycle s+1+k, pulses ready in cycle s+n+1, and frees the
   // controller to accept again in cycle s+n+2.
   bit [7:0]    ref_mem [256];
   int          cyc = 0;
   bit          act_t = 1'b0;
   int          s_cyc = 0;
   int          nb = 0;
   bit          t_data, t_write, t_size;
   logic [7:0]  t_base;
   logic [31:0] t_wdata, t_rword;
   logic [31:0] e_if_data = 32'h0;
   logic [31:0] e_d_rdata = 32'h0;

   always @(negedge Clk) begin
      logic [7:0] e_addr, e_wd, a;
      logic       e_we, e_ifr, e_dr, e_stall;
      int         k;
      if (Reset) begin
         check32("mem_we_during_reset", bus.mem_we, 1'b0);
         act_t = 1'b0;
         e_if_data = 32'h0;
         e_d_rdata = 32'h0;
      end else begin
         if (act_t && cyc > s_cyc + nb + 1) act_t = 1'b0;
         e_addr = 8'h00; e_wd = 8'h00; e_we = 1'b0; e_ifr = 1'b0; e_dr = 1'b0;
         if (act_t && cyc >= s_cyc + 1 && cyc <= s_cyc + nb) begin
            k = cyc - s_cyc - 1;
            e_addr = t_base + 8'(k);
            e_we = t_write;
            if (t_write) e_wd = t_size ? 8'(t_wdata >> (24 - 8 * k)) : t_wdata[7:0];
         end
         if (act_t && cyc == s_cyc + nb + 1) begin
            if (t_data) begin
               e_dr = 1'b1;
               if (!t_write) e_d_rdata = t_rword;
            end else begin
               e_ifr = 1'b1;
               e_if_data = t_rword;
            end
         end
         e_stall = (bus.if_req && !e_ifr) || (bus.d_req && !e_dr);
         check32("mem_addr", bus.mem_addr, e_addr);
         check32("mem_we", bus.mem_we, e_we);
         check32("mem_wdata", bus.mem_wdata, e_wd);
         check32("if_ready", bus.if_ready, e_ifr);
         check32("d_ready", bus.d_ready, e_dr);
         check32("if_data", bus.if_data, e_if_data);
         check32("d_rdata", bus.d_rdata, e_d_rdata);
         check32("stall", bus.stall, e_stall);
         if (e_we) ref_mem[e_addr] = e_wd;
         if (!act_t && (bus.d_req || bus.if_req)) begin
            act_t = 1'b1;
            s_cyc = cyc;
            if (bus.d_req) begin
               t_data = 1'b1; t_write = bus.d_rw; t_size = bus.d_size;
               t_base = bus.d_addr; t_wdata = bus.d_wdata;
            end else begin
               t_data = 1'b0; t_write = 1'b0; t_size = 1'b1;
               t_base = bus.if_addr; t_wdata = 32'h0;
            end
            nb = t_size ? 4 : 1;
            a = t_base;
            if (t_size) t_rword = {ref_mem[a], ref_mem[8'(a + 8'd1)], ref_mem[8'(a + 8'd2)], ref_mem[8'(a + 8'd3)]};
            else        t_rword = {24'h0, ref_mem[a]};
         end
      end
      if (pl_we) ref_mem[pl_addr] = pl_data;
      cyc++;
   end

   task automatic preload(input logic [7:0] a, input logic [7:0] d);
      pl_we = 1'b1; pl_addr = a; pl_data = d;
      @(posedge Clk); #1;
      pl_we = 1'b0;
   endtask

   // Starts a data request in the current cycle (cycle 0); lat = cycle of d_ready.
   task automatic do_data(input logic rw, input logic sz, input logic [7:0] a,
                          input logic [31:0] wd, input bit hold,
                          output int lat, output logic [31:0] rd, output int we_cnt);
      bus.d_req = 1'b1; bus.d_rw = rw; bus.d_size = sz; bus.d_addr = a; bus.d_wdata = wd;
      lat = 0; we_cnt = 0;
      forever begin
         @(negedge Clk);
         if (bus.mem_we) we_cnt++;
         if (bus.d_ready) break;
         lat++;
         if (lat > 40) begin
            checks++; errors++;
            $display("FAIL d_ready_timeout: got no d_ready required within 40 cycles");
            break;
         end
         @(posedge Clk); #1;
         if (!hold) bus.d_req = 1'b0;
      end
      rd = bus.d_rdata;
      @(posedge Clk); #1;
      bus.d_req = 1'b0;
   endtask

   task automatic do_fetch(input logic [7:0] a, output int lat, output logic [31:0] rd,
                           output int stall_cnt);
      bus.if_req = 1'b1; bus.if_addr = a;
      lat = 0; stall_cnt = 0;
      forever begin
         @(negedge Clk);
         if (bus.if_ready) break;
         if (bus.stall) stall_cnt++;
         lat++;
         if (lat > 40) begin
            checks++; errors++;
            $display("FAIL if_ready_timeout: got no if_ready required within 40 cycles");
            break;
         end
         @(posedge Clk); #1;
      end
      rd = bus.if_data;
      @(posedge Clk); #1;
      bus.if_req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, lat2, wc, sc, gap, mism, sel;
      logic [31:0] rd, rd2;
      logic rw, sz;
      logic [7:0] ad;
      logic [31:0] wd;
      bit hold, rdy_seen;

      bus.if_req = 1'b0; bus.if_addr = 8'h00;
      bus.d_req = 1'b0; bus.d_rw = 1'b0; bus.d_size = 1'b0; bus.d_addr = 8'h00; bus.d_wdata = 32'h0;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;

      @(negedge Clk);
      check32("reset_if_data", bus.if_data, 32'h0);
      check32("reset_d_rdata", bus.d_rdata, 32'h0);
      check32("reset_mem_addr", bus.mem_addr, 8'h00);
      check32("reset_mem_we", bus.mem_we, 1'b0);
      check32("reset_readies", {bus.if_ready, bus.d_ready}, 2'b00);
      @(posedge Clk); #1;

      // Instruction fetch of E3 A0 10 05 at 0x10.
      preload(8'h10, 8'hE3); preload(8'h11, 8'hA0); preload(8'h12, 8'h10); preload(8'h13, 8'h05);
      do_fetch(8'h10, lat, rd, sc);
      check32("fetch_latency", lat, 5);
      check32("fetch_data", rd, 32'hE3A01005);
      check32("fetch_stall_cycles", sc, 5);

      // Word store, big-endian.
      do_data(1'b1, 1'b1, 8'h20, 32'hDEADBEEF, 1'b1, lat, rd, wc);
      check32("store_latency", lat, 5);
      check32("store_we_cycles", wc, 4);
      check32("store_bytes", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'hDEADBEEF);

      // Simultaneous data read and fetch: data first, fetch after DONE+IDLE.
      preload(8'h40, 8'h01); preload(8'h41, 8'h23); preload(8'h42, 8'h45); preload(8'h43, 8'h67);
      fork
         do_data(1'b0, 1'b1, 8'h40, 32'h0, 1'b1, lat, rd, wc);
         do_fetch(8'h10, lat2, rd2, sc);
      join
      check32("prio_d_latency", lat, 5);
      check32("prio_d_data", rd, 32'h01234567);
      check32("prio_if_latency", lat2, 11);
      check32("prio_if_data", rd2, 32'hE3A01005);

      // Byte read at the top of memory, then a word read that wraps.
      preload(8'hFF, 8'h7A); preload(8'hFE, 8'h9C); preload(8'h00, 8'h5A); preload(8'h01, 8'h3C);
      do_data(1'b0, 1'b0, 8'hFF, 32'h0, 1'b1, lat, rd, wc);
      check32("byte_latency", lat, 2);
      check32("byte_data", rd, 32'h0000007A);
      do_data(1'b0, 1'b1, 8'hFE, 32'h0, 1'b1, lat, rd, wc);
      check32("wrap_latency", lat, 5);
      check32("wrap_data", rd, 32'h9C7A5A3C);

      // Request pulsed for one cycle still completes.
      do_data(1'b0, 1'b0, 8'h11, 32'h0, 1'b0, lat, rd, wc);
      check32("drop_latency", lat, 2);
      check32("drop_data", rd, 32'h000000A0);

      // Reset during beat 2 of a word store.
      preload(8'h30, 8'h11); preload(8'h31, 8'h11); preload(8'h32, 8'h11); preload(8'h33, 8'h11);
      bus.d_req = 1'b1; bus.d_rw = 1'b1; bus.d_size = 1'b1; bus.d_addr = 8'h30; bus.d_wdata = 32'hCAFEF00D;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      Reset = 1'b1; bus.d_req = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b0;
      @(negedge Clk);
      check32("abort_idle_addr", bus.mem_addr, 8'h00);
      check32("abort_d_rdata", bus.d_rdata, 32'h0);
      rdy_seen = bus.d_ready;
      repeat (8) begin
         @(negedge Clk);
         if (bus.d_ready) rdy_seen = 1'b1;
      end
      check32("abort_no_ready", rdy_seen, 1'b0);
      check32("abort_bytes", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, 32'hCAFE1111);
      @(posedge Clk); #1;

      // Random traffic checked cycle-by-cycle by the model.
      for (int i = 0; i < 60; i++) begin
         sel = int'($urandom_range(0, 3));
         ad = 8'($urandom); wd = $urandom;
         rw = 1'($urandom_range(0, 1)); sz = 1'($urandom_range(0, 1));
         hold = ($urandom_range(0, 3) != 0);
         if (sel <= 1) begin
            do_data(rw, sz, ad, wd, hold, lat, rd, wc);
         end else if (sel == 2) begin
            do_fetch(ad, lat, rd, sc);
         end else begin
            fork
               do_data(rw, sz, ad, wd, hold, lat, rd, wc);
               do_fetch(8'(ad + 8'h80), lat2, rd2, sc);
            join
         end
         gap = int'($urandom_range(0, 2));
         repeat (gap) begin
            @(posedge Clk); #1;
         end
      end

      repeat (3) @(posedge Clk);
      #1;
      mism = 0;
      for (int i = 0; i < 256; i++) begin
         if (mem[i] != ref_mem[i]) mism++;
      end
      check32("final_memory_mismatches", mism, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
